window_generator: RTL and testbench
===================================

Name: window_generator

Overview:
- Raster-scan pixel streamer feeding filter_function; the producer side of filter_function's c/p/enable interface.
- Accepts one pixel per cycle in raster order and buffers MASK_WIDTH-1 full image lines.
- Emits each fully interior MASK_WIDTH x MASK_WIDTH window on the packed p bus with a one-cycle enable strobe, ready for direct connection to filter_function.
- Supplies no coefficients; c is driven elsewhere.

Parameters:
PIX_BIT, 8, bits per pixel
MASK_WIDTH, 7, window side length (odd, >=3)
IMG_WIDTH, 64, pixels per line (>= MASK_WIDTH)
IMG_HEIGHT, 64, lines per frame (>= MASK_WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  pix_in valid this cycle
in_sof  input  1  start of frame; qualified by in_valid, marks pixel (0,0)
pix_in  input  PIX_BIT  incoming pixel
p  output  PIX_BIT*MASK_WIDTH**2  packed window to filter_function
enable  output  1  one-cycle strobe: p holds a valid window
busy  output  1  frame in progress (state ACTIVE)
frame_done  output  1  one-cycle pulse after the last pixel of the frame is accepted

Behaviour:
- Reset (async, active-high): all outputs go to 0 (p, enable, busy, frame_done); state=IDLE; col=0, row=0. Line-buffer RAM contents are not reset and are never observable before refill.
- States:
  - IDLE: ignore in_valid without in_sof. On in_valid&in_sof, accept pixel as (0,0) and go to ACTIVE.
  - ACTIVE: each in_valid accepts one pixel and advances col. When col reaches IMG_WIDTH-1, col wraps to 0 and row increments.
  - On the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1): next cycle frame_done=1 for one cycle, busy=0, state returns to IDLE.
  - in_sof with in_valid while ACTIVE: abort the current frame and restart. That pixel becomes (0,0), no frame_done is issued, and no window from the aborted frame is emitted after that cycle.
- in_valid low: counters, buffers, window and state hold; enable=0. Gaps of any length are legal.
- Line buffers: MASK_WIDTH-1 buffers, each IMG_WIDTH deep, read and written at column col. A pixel accepted at (row,col) shifts up the column at col; the window shift register takes the new column of MASK_WIDTH pixels.
- Window valid condition: the accepted pixel has row>=MASK_WIDTH-1 and col>=MASK_WIDTH-1. Border windows are never emitted (no padding).
- Latency: enable and p are registered, appearing the cycle after the completing pixel is accepted. p holds its value until the next window; enable pulses exactly 1 cycle per window.
- Packing: slice k = p[PIX_BIT*(k+1)-1 -: PIX_BIT], k = r*MASK_WIDTH + c.
  - r=0 is the oldest line (row-MASK_WIDTH+1); c=0 is the leftmost column (col-MASK_WIDTH+1).
  - The highest slice (k=MASK_WIDTH**2-1) is the just-accepted pixel.
- Windows per frame: exactly (IMG_WIDTH-MASK_WIDTH+1)*(IMG_HEIGHT-MASK_WIDTH+1).
- Column wrap: window columns never mix data from line N's end with line N+1's start. The first MASK_WIDTH-1 pixels of each line only prime the shift register.
- Back-to-back frames: in_sof on the cycle after the last pixel is legal. frame_done is still pulsed for the completed frame.
- Counters are sized by $clog2 of IMG_WIDTH and IMG_HEIGHT; no arithmetic overflow is possible.

Test Plan:
- Full frame: MASK_WIDTH=3, IMG_WIDTH=IMG_HEIGHT=8, pixel value = row*8+col, continuous in_valid.
  - 36 enable pulses.
  - First pulse is 1 cycle after pixel (2,2); that p has slices k=0..8 = 0,1,2,8,9,10,16,17,18.
  - Last window is centred at (6,6).
  - frame_done is 1 cycle after pixel (7,7).
- Defaults (7/64/64), all pixels 255: 3364 windows, every slice 255 (matches the filter_function all-255 case). A second frame of all 0 yields only 0 windows; no 255 leakage.
- Random in_valid gaps (~50% duty), same stimulus as the first scenario: identical window sequence and count; enable never asserted while the pipe is stalled by gaps.
- Mid-frame restart: in_sof at pixel (4,3) of the first frame.
  - No frame_done for the aborted frame.
  - The new frame yields exactly 36 correct windows.
- Reset mid-frame after 20 pixels: all outputs 0 immediately (async, before the next clk edge). in_valid without in_sof is then ignored until in_sof; the following frame is correct.
- IDLE filtering: 10 pixels with in_valid and no in_sof produce no enable and no busy. in_sof on the cycle after frame_done starts the next frame cleanly.

Source files
------------

// File: rtl/window_generator.sv
// Raster-scan window generator: buffers MASK_WIDTH-1 image lines and emits every
// fully interior MASK_WIDTH x MASK_WIDTH window on p with a one-cycle enable strobe.
module window_generator #(
  parameter int unsigned PIX_BIT    = 8,
  parameter int unsigned MASK_WIDTH = 7,
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic                                   in_sof,
  input  logic [PIX_BIT-1:0]                     pix_in,
  output logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] p,
  output logic                                   enable,
  output logic                                   busy,
  output logic                                   frame_done
);

  localparam int unsigned NLB = MASK_WIDTH - 1;
  localparam int unsigned CW  = $clog2(IMG_WIDTH);
  localparam int unsigned RW  = $clog2(IMG_HEIGHT);
  localparam int unsigned PW  = PIX_BIT * MASK_WIDTH * MASK_WIDTH;
  localparam int          MW  = int'(MASK_WIDTH);
  localparam int          NL  = int'(NLB);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(MASK_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(MASK_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [RW-1:0]     row_q, row_d, cur_row;
  logic [PW-1:0]     p_q, p_d;
  logic              enable_q, enable_d;
  logic              frame_done_q, frame_done_d;
  logic              acc;

  logic [PIX_BIT-1:0] lb_mem  [NLB][IMG_WIDTH];
  logic [PIX_BIT-1:0] col_pix [MASK_WIDTH];
  logic [PIX_BIT-1:0] win_q   [MASK_WIDTH][MASK_WIDTH];
  logic [PIX_BIT-1:0] win_d   [MASK_WIDTH][MASK_WIDTH];

  // A start-of-frame pixel is always position (0,0), even mid-frame.
  always_comb begin
    acc     = in_valid && (in_sof || (state_q == ACTIVE));
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
  end

  // Vertical column at cur_col: oldest line first, incoming pixel last.
  always_comb begin
    for (int r = 0; r < NL; r++) col_pix[r] = lb_mem[r][cur_col];
    col_pix[MW-1] = pix_in;
  end

  // Line buffers are plain storage; rows are refilled before they are ever used.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < NL; r++) lb_mem[r][cur_col] <= col_pix[r+1];
    end
  end

  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int r = 0; r < MW; r++) begin
        for (int c = 0; c < MW - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][MW-1] = col_pix[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  // Next-state, position counters and registered window output.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    p_d          = p_q;
    enable_d     = 1'b0;
    frame_done_d = 1'b0;
    if (acc) begin
      if ((cur_row >= ROW_MIN) && (cur_col >= COL_MIN)) begin
        enable_d = 1'b1;
        for (int r = 0; r < MW; r++) begin
          for (int c = 0; c < MW; c++) begin
            p_d[PIX_BIT*(r*MW+c) +: PIX_BIT] = win_d[r][c];
          end
        end
      end
      if ((cur_row == ROW_LAST) && (cur_col == COL_LAST)) begin
        state_d      = IDLE;
        col_d        = '0;
        row_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        state_d = ACTIVE;
        if (cur_col == COL_LAST) begin
          col_d = '0;
          row_d = cur_row + RW'(1);
        end else begin
          col_d = cur_col + CW'(1);
          row_d = cur_row;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      p_q          <= '0;
      enable_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      p_q          <= p_d;
      enable_q     <= enable_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign p          = p_q;
  assign enable     = enable_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == ACTIVE);

endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator: a 3/8/8 instance and a default 7/64/64 instance,
// both compared every cycle against an image-array reference model.
module tb_window_generator;

  localparam int unsigned PS = 72;
  localparam int unsigned PD = 392;

  logic          clk;
  logic          reset;
  logic          v_s, sof_s, en_s, busy_s, fd_s;
  logic [7:0]    pix_s;
  logic [PS-1:0] p_s;
  logic          v_d, sof_d, en_d, busy_d, fd_d;
  logic [7:0]    pix_d;
  logic [PD-1:0] p_d;

  window_generator #(.PIX_BIT(8), .MASK_WIDTH(3), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_s (
    .clk(clk), .reset(reset), .in_valid(v_s), .in_sof(sof_s), .pix_in(pix_s),
    .p(p_s), .enable(en_s), .busy(busy_s), .frame_done(fd_s)
  );

  window_generator #(.PIX_BIT(8), .MASK_WIDTH(7), .IMG_WIDTH(64), .IMG_HEIGHT(64)) dut_d (
    .clk(clk), .reset(reset), .in_valid(v_d), .in_sof(sof_d), .pix_in(pix_d),
    .p(p_d), .enable(en_d), .busy(busy_d), .frame_done(fd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = small instance, 1 = default instance.
  logic [7:0]    img [2][64][64];
  int            mrow [2];
  int            mcol [2];
  bit            mact [2];
  logic [PD-1:0] mp [2];
  int            en_seen [2];
  int            fd_seen [2];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [PD-1:0] obs, input logic [PD-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      mact[b] = 1'b0;
      mrow[b] = 0;
      mcol[b] = 0;
      mp[b]   = '0;
    end
  endtask

  // One clock of stimulus to instance b, then model update and output check.
  task automatic step(input int b, input bit v, input bit sof, input logic [7:0] pix);
    int m, w, r, c;
    bit ex_en, ex_fd;
    logic [PD-1:0] op;
    logic oe, ob, of;
    @(negedge clk);
    v_s = (b == 0) && v;  sof_s = sof;  pix_s = pix;
    v_d = (b == 1) && v;  sof_d = sof;  pix_d = pix;
    @(posedge clk);
    #1;
    m = (b == 1) ? 7 : 3;
    w = (b == 1) ? 64 : 8;
    ex_en = 1'b0;
    ex_fd = 1'b0;
    if (v && (sof || mact[b])) begin
      r = sof ? 0 : mrow[b];
      c = sof ? 0 : mcol[b];
      img[b][r][c] = pix;
      if (r >= m - 1 && c >= m - 1) begin
        ex_en = 1'b1;
        mp[b] = '0;
        for (int i = 0; i < m; i++)
          for (int j = 0; j < m; j++)
            mp[b][8*(i*m+j) +: 8] = img[b][r-m+1+i][c-m+1+j];
      end
      if (r == w - 1 && c == w - 1) begin
        mact[b] = 1'b0;
        ex_fd   = 1'b1;
      end else begin
        mact[b] = 1'b1;
        mcol[b] = (c == w - 1) ? 0 : c + 1;
        mrow[b] = (c == w - 1) ? r + 1 : r;
      end
    end
    if (b == 1) begin
      op = p_d;  oe = en_d;  ob = busy_d;  of = fd_d;
    end else begin
      op = PD'(p_s);  oe = en_s;  ob = busy_s;  of = fd_s;
    end
    chk("enable", PD'(oe), PD'(ex_en));
    chk("p", op, mp[b]);
    chk("busy", PD'(ob), PD'(mact[b]));
    chk("frame_done", PD'(of), PD'(ex_fd));
    if (oe) en_seen[b]++;
    if (of) fd_seen[b]++;
  endtask

  // Pixels k0..k1-1 of a frame; mode 0 = row*8+col, 1 = 255, 2 = 0, 3 = random.
  task automatic run_frame(input int b, input bit gaps, input int mode, input int k0, input int k1);
    int w, r, c, g;
    logic [7:0] px;
    w = (b == 1) ? 64 : 8;
    for (int k = k0; k < k1; k++) begin
      r = k / w;
      c = k % w;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int i = 0; i < g; i++) step(b, 1'b0, 1'b0, 8'($urandom));
      case (mode)
        0:       px = 8'(r * 8 + c);
        1:       px = 8'hFF;
        2:       px = 8'h00;
        default: px = 8'($urandom);
      endcase
      step(b, 1'b1, (k == 0), px);
    end
  endtask

  initial begin
    reset = 1'b1;
    v_s = 1'b0; sof_s = 1'b0; pix_s = '0;
    v_d = 1'b0; sof_d = 1'b0; pix_d = '0;
    model_reset();
    #2;
    chk("reset_p_s", PD'(p_s), '0);
    chk("reset_en_s", PD'(en_s), '0);
    chk("reset_busy_s", PD'(busy_s), '0);
    chk("reset_fd_s", PD'(fd_s), '0);
    chk("reset_p_d", p_d, '0);
    chk("reset_busy_d", PD'(busy_d), '0);
    @(negedge clk);
    reset = 1'b0;

    // Pixels without a start-of-frame are ignored in IDLE.
    for (int k = 0; k < 10; k++) step(0, 1'b1, 1'b0, 8'(k + 1));

    // Full continuous frame with a directed look at the first and last windows.
    en_seen[0] = 0; fd_seen[0] = 0;
    run_frame(0, 1'b0, 0, 0, 19);
    chk("first_win_en", PD'(en_s), PD'(1'b1));
    chk("first_win_p", PD'(p_s), PD'(72'h121110_0A0908_020100));
    run_frame(0, 1'b0, 0, 19, 64);
    chk("last_win_newest", PD'(p_s[71:64]), PD'(8'd63));
    chk("last_win_centre", PD'(p_s[39:32]), PD'(8'd54));
    chk("fd_after_last", PD'(fd_s), PD'(1'b1));
    chk("win_count_full", PD'(en_seen[0]), PD'(36));
    chk("fd_count_full", PD'(fd_seen[0]), PD'(1));

    // Start on the cycle after frame_done, with random input gaps.
    step(0, 1'b0, 1'b0, 8'h00);
    en_seen[0] = 0; fd_seen[0] = 0;
    run_frame(0, 1'b1, 0, 0, 64);
    chk("win_count_gaps", PD'(en_seen[0]), PD'(36));
    chk("fd_count_gaps", PD'(fd_seen[0]), PD'(1));

    // Mid-frame restart at (4,3).
    fd_seen[0] = 0;
    run_frame(0, 1'b0, 3, 0, 35);
    en_seen[0] = 0;
    run_frame(0, 1'b0, 0, 0, 64);
    chk("win_count_restart", PD'(en_seen[0]), PD'(36));
    chk("fd_count_restart", PD'(fd_seen[0]), PD'(1));

    // Asynchronous reset after 20 pixels, then IDLE filtering and a clean frame.
    run_frame(0, 1'b0, 0, 0, 20);
    chk("pre_reset_en", PD'(en_s), PD'(1'b1));
    reset = 1'b1;
    #1;
    chk("async_p", PD'(p_s), '0);
    chk("async_en", PD'(en_s), '0);
    chk("async_busy", PD'(busy_s), '0);
    chk("async_fd", PD'(fd_s), '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) step(0, 1'b1, 1'b0, 8'($urandom));
    en_seen[0] = 0; fd_seen[0] = 0;
    run_frame(0, 1'b1, 3, 0, 64);
    chk("win_count_post_reset", PD'(en_seen[0]), PD'(36));
    chk("fd_count_post_reset", PD'(fd_seen[0]), PD'(1));

    // Default geometry: all-255 frame then back-to-back all-0 frame.
    en_seen[1] = 0; fd_seen[1] = 0;
    run_frame(1, 1'b0, 1, 0, 4096);
    chk("win_count_255", PD'(en_seen[1]), PD'(3364));
    chk("p_all_255", p_d, {PD{1'b1}});
    en_seen[1] = 0;
    run_frame(1, 1'b0, 2, 0, 4096);
    chk("win_count_0", PD'(en_seen[1]), PD'(3364));
    chk("fd_count_default", PD'(fd_seen[1]), PD'(2));
    chk("p_all_0", p_d, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
